vram_arbiter: RTL

Single-port framebuffer arbiter between the VGA scan-out path and the game-logic writer. It runs on the 100 MHz system clock alongside the 640x480 timing generator and consumes its 25 MHz pixel strobe, active flag and x/y position. On every active pixel strobe it guarantees a framebuffer read, so the display never stalls. Between strobes it serves the writer's read/write requests through a req/ack handshake. The framebuffer is 160x120 x 8 bit; each stored pixel covers a 4x4 block of screen pixels.

---
 rtl/vram_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: video scan-out reads win every active pixel strobe,
// and the game-logic writer is served in the free slots through a req/ack handshake.
module vram_arbiter #(
    parameter int FB_W = 160,
    parameter int FB_H = 120,
    parameter int AW   = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    input  logic          i_active,
    input  logic [9:0]    i_x,
    input  logic [9:0]    i_y,
    input  logic          i_wr_req,
    input  logic          i_wr_we,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    output logic          o_wr_ack,
    output logic [7:0]    o_wr_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [7:0]    o_mem_wdata,
    input  logic [7:0]    i_mem_rdata,
    output logic [7:0]    o_pixel
);

    localparam logic [AW-1:0] FB_SIZE = AW'(FB_W * FB_H);
    localparam logic [1:0] V_NONE = 2'd0;
    localparam logic [1:0] V_PIX  = 2'd1;
    localparam logic [1:0] V_BLK  = 2'd2;

    typedef enum logic [2:0] {
        W_IDLE,
        W_WRITE,
        W_RD1,
        W_RD2,
        W_HOLD
    } wstate_t;

    wstate_t       r_state;
    wstate_t       w_state_nxt;
    logic          w_grant;
    logic          w_ack_nxt;

    logic          w_vid;
    logic          w_blk;
    logic          w_in_range;
    logic [AW-1:0] w_yb;
    logic [AW-1:0] w_vaddr;

    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [7:0]    r_mem_wdata;
    logic [7:0]    r_pixel;
    logic [7:0]    r_wr_rdata;
    logic          r_wr_ack;
    logic          r_rd_oor;
    logic [1:0]    r_vt0;
    logic [1:0]    r_vt1;
    logic          r_rt0;
    logic          r_rt1;

    assign w_vid      = i_pix_stb & i_active;
    assign w_blk      = i_pix_stb & ~i_active;
    assign w_in_range = (i_wr_addr < FB_SIZE);

    // (y>>2)*160 as (y<<7)+(y<<5); the largest result (19199) fits without wrap.
    assign w_yb    = AW'(i_y[9:2]);
    assign w_vaddr = (w_yb << 7) + (w_yb << 5) + AW'(i_x[9:2]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= W_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = i_wr_we ? W_WRITE : W_RD1;
                end
            end
            W_WRITE: w_state_nxt = W_HOLD;
            W_RD1:   w_state_nxt = W_RD2;
            W_RD2:   w_state_nxt = W_HOLD;
            W_HOLD:  w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // W_HOLD keeps a still-high request from re-issuing in the cycle ack is visible.
    always_comb begin
        w_grant   = (r_state == W_IDLE) & i_wr_req & ~w_vid;
        w_ack_nxt = (r_state == W_WRITE) | (r_state == W_RD2);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_pixel     <= '0;
            r_wr_rdata  <= '0;
            r_wr_ack    <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_vt0       <= V_NONE;
            r_vt1       <= V_NONE;
            r_rt0       <= 1'b0;
            r_rt1       <= 1'b0;
        end else begin
            if (w_vid) begin
                r_mem_addr <= w_vaddr;
                r_mem_we   <= 1'b0;
            end else if (w_grant) begin
                r_mem_addr  <= i_wr_addr;
                r_mem_we    <= i_wr_we & w_in_range;
                r_mem_wdata <= i_wr_data;
            end else begin
                r_mem_we <= 1'b0;
            end

            if (w_grant) begin
                r_rd_oor <= ~w_in_range;
            end

            // Video and writer-read tags travel separately so a return in either
            // lane can never be steered into the other.
            r_vt0 <= w_vid ? V_PIX : (w_blk ? V_BLK : V_NONE);
            r_vt1 <= r_vt0;
            r_rt0 <= w_grant & ~i_wr_we;
            r_rt1 <= r_rt0;

            case (r_vt1)
                V_PIX:   r_pixel <= i_mem_rdata;
                V_BLK:   r_pixel <= '0;
                default: r_pixel <= r_pixel;
            endcase

            if (r_rt1) begin
                r_wr_rdata <= r_rd_oor ? 8'h00 : i_mem_rdata;
            end

            r_wr_ack <= w_ack_nxt;
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_mem_wdata;
    assign o_pixel     = r_pixel;
    assign o_wr_rdata  = r_wr_rdata;
    assign o_wr_ack    = r_wr_ack;

endmodule
